// File: rtl/alarm_clock_fsm_if.sv
`default_nettype none
// ============================================================================
// Module  : alarm_clock_fsm_if
// Brief   : Keypad/button inputs and display/register strobes of the alarm
//           clock control FSM.
// Revision: 1.0 - initial release
// ============================================================================
interface alarm_clock_fsm_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       show_new_time;
    logic       show_alarm;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic       reset_count;

    modport master (
        output one_second, key, alarm_button, time_button,
        input  show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count
    );

    modport slave (
        input  one_second, key, alarm_button, time_button,
        output show_new_time, show_alarm, shift, load_new_a, load_new_c, reset_count
    );
endinterface
`default_nettype wire

// File: rtl/alarm_clock_fsm.sv
`default_nettype none
// ============================================================================
// Module  : alarm_clock_fsm
// Brief   : Moore control FSM for the alarm clock. Define ALARM_FSM_TIMEOUT_EN
//           to build the key-entry inactivity timeout.
// Revision: 1.0 - initial release
// ============================================================================
module alarm_clock_fsm #(
    parameter int         TIMEOUT_SEC = 9,
    parameter logic [3:0] NOKEY       = 4'd10
) (
    input  wire logic        clock,
    input  wire logic        reset,
    alarm_clock_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_SHOW_TIME        = 3'd0,
        S_KEY_STORED       = 3'd1,
        S_KEY_WAITED       = 3'd2,
        S_KEY_ENTRY        = 3'd3,
        S_SHOW_ALARM       = 3'd4,
        S_SET_ALARM_TIME   = 3'd5,
        S_SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   key_pressed;
    logic   timeout;

    assign key_pressed = (bus.key != NOKEY);

`ifdef ALARM_FSM_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_VAL = 4'(TIMEOUT_SEC);

    logic [3:0] count_q, count_d;

    // Counts only while waiting on the keypad; saturates instead of wrapping.
    always_comb begin
        count_d = 4'd0;
        if (state_q == S_KEY_WAITED || state_q == S_KEY_ENTRY) begin
            count_d = count_q;
            if (bus.one_second && count_q != TIMEOUT_VAL) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = (count_q == TIMEOUT_VAL);
`else
    logic unused_one_second;
    assign unused_one_second = bus.one_second;
    assign timeout           = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_SHOW_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SHOW_TIME: begin
                if (bus.alarm_button)  state_d = S_SHOW_ALARM;
                else if (key_pressed)  state_d = S_KEY_STORED;
            end
            S_KEY_STORED: state_d = S_KEY_WAITED;
            S_KEY_WAITED: begin
                if (!key_pressed)      state_d = S_KEY_ENTRY;
                else if (timeout)      state_d = S_SHOW_TIME;
            end
            // Buttons beat keys, and a fresh key beats an expiring timeout.
            S_KEY_ENTRY: begin
                if (bus.alarm_button)      state_d = S_SET_ALARM_TIME;
                else if (bus.time_button)  state_d = S_SET_CURRENT_TIME;
                else if (key_pressed)      state_d = S_KEY_STORED;
                else if (timeout)          state_d = S_SHOW_TIME;
            end
            S_SHOW_ALARM: begin
                if (!bus.alarm_button) state_d = S_SHOW_TIME;
            end
            S_SET_ALARM_TIME:   state_d = S_SHOW_TIME;
            S_SET_CURRENT_TIME: state_d = S_SHOW_TIME;
            default:            state_d = S_SHOW_TIME;
        endcase
    end

    assign bus.show_new_time = (state_q == S_KEY_STORED) ||
                               (state_q == S_KEY_WAITED) ||
                               (state_q == S_KEY_ENTRY);
    assign bus.show_alarm    = (state_q == S_SHOW_ALARM);
    assign bus.shift         = (state_q == S_KEY_STORED);
    assign bus.load_new_a    = (state_q == S_SET_ALARM_TIME);
    assign bus.load_new_c    = (state_q == S_SET_CURRENT_TIME);
    assign bus.reset_count   = (state_q == S_SET_CURRENT_TIME);

endmodule
`default_nettype wire
